// File: rtl/tdp_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tdp_initiator
//  Brief    : Burst initiator for a single memory port. Accepts a burst
//             command {wr, len, addr}, then either streams write payload into
//             sequential memory writes or issues sequential reads and forwards
//             the in-order responses downstream, tagging the last word (eot).
//  Revision : 1.0 - initial release
// ============================================================================
module tdp_initiator #(
  parameter int W_DATA = 16,
  parameter int W_ADDR = 16,
  parameter int W_LEN  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  // burst command {wr, len, addr}
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [W_ADDR+W_LEN:0]    cmd_data,
  // write payload stream
  input  logic                     wdat_valid,
  output logic                     wdat_ready,
  input  logic [W_DATA-1:0]        wdat_data,
  // memory request {ctrl, data, addr}
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic [W_DATA+W_ADDR:0]   req_data,
  // memory read responses
  input  logic                     dout_valid,
  output logic                     dout_ready,
  input  logic [W_DATA-1:0]        dout_data,
  // read data to downstream {eot, data}
  output logic                     rdat_valid,
  input  logic                     rdat_ready,
  output logic [W_DATA:0]          rdat_data,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR    = 2'd1,
    S_RD    = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [W_ADDR-1:0] r_addr;
  logic [W_LEN-1:0]  r_len;
  logic              r_wr;
  logic [W_LEN-1:0]  r_icnt;
  logic [W_LEN-1:0]  r_rcnt;

  logic [W_ADDR-1:0] w_req_addr;
  logic              w_req_last;
  logic              w_eot;
  logic              w_cmd_hs;
  logic              w_req_hs;
  logic              w_rdat_hs;

  // Address of the current beat; the adder width makes it wrap naturally.
  assign w_req_addr = r_addr + W_ADDR'(r_icnt);
  assign w_req_last = (r_icnt == r_len);
  assign w_eot      = (r_rcnt == r_len);
  assign w_cmd_hs   = cmd_valid & cmd_ready;
  assign w_req_hs   = req_valid & req_ready;
  assign w_rdat_hs  = rdat_valid & rdat_ready;
  assign busy       = (r_state != S_IDLE);

  // State register; reset drops any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and all handshake/data outputs, purely combinational.
  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    wdat_ready  = 1'b0;
    req_valid   = 1'b0;
    req_data    = '0;
    dout_ready  = 1'b0;
    rdat_valid  = 1'b0;
    rdat_data   = {w_eot, dout_data};
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_state_nxt = cmd_data[W_ADDR+W_LEN] ? S_WR : S_RD;
        end
      end
      S_WR: begin
        req_valid  = wdat_valid;
        wdat_ready = req_ready;
        req_data   = {r_wr, wdat_data, w_req_addr};
        if (wdat_valid && req_ready && w_req_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        req_valid  = 1'b1;
        req_data   = {r_wr, {W_DATA{1'b0}}, w_req_addr};
        rdat_valid = dout_valid;
        dout_ready = rdat_ready;
        if (req_ready && w_req_last) begin
          // Last response leaving together with the last request ends the burst.
          w_state_nxt = (dout_valid && rdat_ready && w_eot) ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        rdat_valid = dout_valid;
        dout_ready = rdat_ready;
        if (dout_valid && rdat_ready && w_eot) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command capture plus issue/response beat counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_len  <= '0;
      r_wr   <= 1'b0;
      r_icnt <= '0;
      r_rcnt <= '0;
    end else if (w_cmd_hs) begin
      r_addr <= cmd_data[W_ADDR-1:0];
      r_len  <= cmd_data[W_ADDR+W_LEN-1:W_ADDR];
      r_wr   <= cmd_data[W_ADDR+W_LEN];
      r_icnt <= '0;
      r_rcnt <= '0;
    end else begin
      if (w_req_hs) begin
        r_icnt <= r_icnt + 1'b1;
      end
      if (w_rdat_hs) begin
        r_rcnt <= r_rcnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdp_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_tdp_initiator
//  Brief    : Self-checking bench for tdp_initiator with a 1-cycle memory
//             model, table-driven bursts and an in-order scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdp_initiator;

  localparam int TMO = 5000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT signals (W_DATA=16, W_ADDR=16, W_LEN=8)
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [24:0] cmd_data  = '0;
  logic        wdat_valid = 1'b0;
  logic        wdat_ready;
  logic [15:0] wdat_data = '0;
  logic        req_valid;
  logic        req_ready;
  logic [32:0] req_data;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] dout_data;
  logic        rdat_valid;
  logic        rdat_ready = 1'b1;
  logic [16:0] rdat_data;
  logic        busy;

  // narrow-address DUT signals (W_ADDR=4)
  logic        c4_valid  = 1'b0;
  logic        c4_ready;
  logic [12:0] c4_data   = '0;
  logic        wd4_valid = 1'b0;
  logic        wd4_ready;
  logic [15:0] wd4_data  = '0;
  logic        rq4_valid;
  logic        rq4_ready = 1'b1;
  logic [20:0] rq4_data;
  logic        do4_valid = 1'b0;
  logic        do4_ready;
  logic [15:0] do4_data  = '0;
  logic        rd4_valid;
  logic        rd4_ready = 1'b1;
  logic [16:0] rd4_data;
  logic        busy4;

  tdp_initiator #(.W_DATA(16), .W_ADDR(16), .W_LEN(8)) u_dut (
    .clk(clk), .rst(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data),
    .busy(busy)
  );

  tdp_initiator #(.W_DATA(16), .W_ADDR(4), .W_LEN(8)) u_dut4 (
    .clk(clk), .rst(rst_n),
    .cmd_valid(c4_valid), .cmd_ready(c4_ready), .cmd_data(c4_data),
    .wdat_valid(wd4_valid), .wdat_ready(wd4_ready), .wdat_data(wd4_data),
    .req_valid(rq4_valid), .req_ready(rq4_ready), .req_data(rq4_data),
    .dout_valid(do4_valid), .dout_ready(do4_ready), .dout_data(do4_data),
    .rdat_valid(rd4_valid), .rdat_ready(rd4_ready), .rdat_data(rd4_data),
    .busy(busy4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model: 1-cycle read latency, 2-deep response FIFO
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] mfifo   [0:1];
  logic        mrp, mwp;
  logic [1:0]  mcnt;
  logic        m_stall;
  bit          m_bp  = 1'b0;
  bit          rd_bp = 1'b0;

  assign req_ready  = (mcnt != 2'd2) && !m_stall;
  assign dout_valid = (mcnt != 2'd0);
  assign dout_data  = mfifo[mrp];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrp <= 1'b0; mwp <= 1'b0; mcnt <= 2'd0; m_stall <= 1'b0;
    end else begin
      m_stall <= m_bp && ($urandom_range(0, 3) == 0);
      if (req_valid && req_ready) begin
        if (req_data[32]) mem[req_data[15:0]] <= req_data[31:16];
        else begin
          mfifo[mwp] <= mem[req_data[15:0]];
          mwp        <= ~mwp;
        end
      end
      if (dout_valid && dout_ready) mrp <= ~mrp;
      if ((req_valid && req_ready && !req_data[32]) && !(dout_valid && dout_ready)) mcnt <= mcnt + 2'd1;
      else if (!(req_valid && req_ready && !req_data[32]) && (dout_valid && dout_ready)) mcnt <= mcnt - 2'd1;
    end
  end

  // random downstream backpressure during selected reads
  initial begin
    forever begin
      @(posedge clk); #1;
      rdat_ready = rd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard monitor (samples on falling edge)
  logic [32:0] q_req [$];
  logic [16:0] q_rd  [$];
  int          n_req, n_rd, n_eot;
  logic [15:0] last_addr;
  logic        held_v = 1'b0;
  logic [32:0] held_d;
  logic [32:0] e_req;
  logic [16:0] e_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v) cmp("req_hold_stable", 64'({req_valid, req_data}), 64'({1'b1, held_d}));
      held_v = req_valid && !req_ready;
      held_d = req_data;
      if (req_valid && req_ready) begin
        n_req++;
        last_addr = req_data[15:0];
        if (q_req.size() == 0) begin
          checks++; failures++;
          $display("FAIL req_extra: got %0h expected none", req_data);
        end else begin
          e_req = q_req.pop_front();
          cmp("req_data", 64'(req_data), 64'(e_req));
        end
      end
      if (rdat_valid && rdat_ready) begin
        n_rd++;
        if (rdat_data[16]) n_eot++;
        if (q_rd.size() == 0) begin
          checks++; failures++;
          $display("FAIL rdat_extra: got %0h expected none", rdat_data);
        end else begin
          e_rd = q_rd.pop_front();
          cmp("rdat_data", 64'(rdat_data), 64'(e_rd));
        end
      end
    end
  end

  // ---------------- burst table
  typedef struct {
    bit          wr;
    int          len;
    logic [15:0] addr;
    logic [15:0] dbase;
    bit          bp;
    logic [15:0] exp_last;
  } burst_t;

  burst_t tbl [8];

  // Called at a falling edge; launches the command in the first idle cycle.
  task automatic run_burst(input burst_t b);
    int          t;
    bit          acc;
    logic [15:0] a;
    logic        e;
    n_req = 0; n_rd = 0; n_eot = 0;
    for (int i = 0; i <= b.len; i++) begin
      a = b.addr + 16'(i);
      e = (i == b.len);
      if (b.wr) begin
        ref_mem[a] = b.dbase + 16'(i);
        q_req.push_back({1'b1, b.dbase + 16'(i), a});
      end else begin
        q_req.push_back({1'b0, 16'h0000, a});
        q_rd.push_back({e, ref_mem[a]});
      end
    end
    t = 0;
    while (busy && t < TMO) begin @(negedge clk); t++; end
    #1;
    m_bp  = b.bp;
    rd_bp = b.bp && !b.wr;
    cmp("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_data  = {b.wr, 8'(b.len), b.addr};
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmp("busy_cmdready_after_cmd", 64'({busy, cmd_ready}), 64'(2'b10));
    if (!b.wr) cmp("first_req_valid", 64'(req_valid), 64'(1));
    if (b.wr) begin
      for (int i = 0; i <= b.len; i++) begin
        if (b.bp && ($urandom_range(0, 1) == 1)) begin
          wdat_valid = 1'b0;
          @(posedge clk); #1;
        end
        wdat_valid = 1'b1;
        wdat_data  = b.dbase + 16'(i);
        acc = 1'b0; t = 0;
        while (!acc && t < TMO) begin
          @(negedge clk); acc = wdat_ready;
          @(posedge clk); #1; t++;
        end
        if (!acc) begin
          checks++; failures++;
          $display("FAIL wdat_timeout: got no handshake expected word %0d", i);
        end
      end
      wdat_valid = 1'b0;
      cmp("wr_busy_fall", 64'(busy), 64'(0));
    end
    @(negedge clk);
    t = 0;
    while (busy && t < TMO) begin @(negedge clk); t++; end
    if (busy) begin
      checks++; failures++;
      $display("FAIL burst_timeout: got busy=1 expected busy=0");
    end
    m_bp = 1'b0; rd_bp = 1'b0;
    cmp("req_count", 64'(n_req), 64'(b.len + 1));
    cmp("last_addr", 64'(last_addr), 64'(b.exp_last));
    cmp("rdat_count", 64'(n_rd), b.wr ? 64'(0) : 64'(b.len + 1));
    cmp("eot_count", 64'(n_eot), b.wr ? 64'(0) : 64'(1));
    cmp("sb_empty", 64'(q_req.size() + q_rd.size()), 64'(0));
  endtask

  // Read len=7 at 0x100, reset right after its second request.
  task automatic run_reset_mid();
    int          t;
    logic [15:0] a;
    logic        e;
    n_req = 0; n_rd = 0; n_eot = 0;
    for (int i = 0; i <= 7; i++) begin
      a = 16'h0100 + 16'(i);
      e = (i == 7);
      q_req.push_back({1'b0, 16'h0000, a});
      q_rd.push_back({e, ref_mem[a]});
    end
    #1;
    cmd_valid = 1'b1;
    cmd_data  = {1'b0, 8'd7, 16'h0100};
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    while (n_req < 2 && t < TMO) begin @(negedge clk); t++; end
    cmp("rst_mid_two_reqs", 64'(n_req), 64'(2));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    cmp("rst_mid_outputs",
        64'({busy, cmd_ready, req_valid, wdat_ready, dout_ready, rdat_valid}), 64'(6'b010000));
    q_req.delete();
    q_rd.delete();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Narrow-address instance: read len=3 at 0xE must wrap to 0x0, 0x1.
  task automatic run_wrap();
    logic [3:0] ea [4];
    int         k, t;
    logic       e;
    ea[0] = 4'hE; ea[1] = 4'hF; ea[2] = 4'h0; ea[3] = 4'h1;
    @(negedge clk); #1;
    cmp("wrap_cmd_ready", 64'(c4_ready), 64'(1));
    c4_valid = 1'b1;
    c4_data  = {1'b0, 8'd3, 4'hE};
    @(posedge clk); #1;
    c4_valid = 1'b0;
    k = 0; t = 0;
    while (k < 4 && t < 50) begin
      @(negedge clk); t++;
      if (rq4_valid) begin
        cmp("wrap_addr", 64'({rq4_data[20], rq4_data[3:0]}), 64'({1'b0, ea[k]}));
        cmp("wrap_wdat_ready", 64'(wd4_ready), 64'(0));
        k++;
      end
    end
    cmp("wrap_req_count", 64'(k), 64'(4));
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      e = (j == 3);
      do4_valid = 1'b1;
      do4_data  = 16'h0100 + 16'(j);
      @(negedge clk);
      cmp("wrap_rdat", 64'({rd4_valid, do4_ready, rd4_data}), 64'({1'b1, 1'b1, e, 16'h0100 + 16'(j)}));
      @(posedge clk); #1;
    end
    do4_valid = 1'b0;
    cmp("wrap_done", 64'(busy4), 64'(0));
  endtask

  initial begin
    tbl[0] = '{1'b1, 3,   16'h0010, 16'h000A, 1'b0, 16'h0013};
    tbl[1] = '{1'b0, 3,   16'h0010, 16'h0000, 1'b0, 16'h0013};
    tbl[2] = '{1'b1, 0,   16'h0020, 16'h0055, 1'b0, 16'h0020};
    tbl[3] = '{1'b0, 0,   16'h0020, 16'h0000, 1'b0, 16'h0020};
    tbl[4] = '{1'b1, 7,   16'h0100, 16'h1000, 1'b1, 16'h0107};
    tbl[5] = '{1'b0, 7,   16'h0100, 16'h0000, 1'b1, 16'h0107};
    tbl[6] = '{1'b1, 255, 16'hFF80, 16'h2000, 1'b0, 16'h007F};
    tbl[7] = '{1'b0, 255, 16'hFF80, 16'h0000, 1'b1, 16'h007F};

    #12;
    cmp("reset_outputs",
        64'({busy, cmd_ready, req_valid, wdat_ready, dout_ready, rdat_valid}), 64'(6'b010000));
    cmp("reset_outputs_w4", 64'({busy4, c4_ready, rq4_valid, rd4_valid}), 64'(4'b0100));
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_burst(tbl[i]);
    run_reset_mid();
    run_burst(tbl[5]);
    run_burst(tbl[1]);
    run_wrap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tdp_initiator.md
TDP_INITIATOR -- requirements
Module: tdp_initiator

Interface
REQ-001 SHALL have parameter W_DATA, default 16, data word width.
REQ-002 SHALL have parameter W_ADDR, default 16, memory address width.
REQ-003 SHALL have parameter W_LEN, default 8, burst length field width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_data in W_ADDR+W_LEN+1: {wr[MSB], len, addr[LSB]}; len = word count minus 1.
REQ-007 SHALL have ports wdat_valid in 1, wdat_ready out 1, wdat_data in W_DATA: write payload stream.
REQ-008 SHALL have ports req_valid out 1, req_ready in 1, req_data out W_DATA+W_ADDR+1: {ctrl[MSB], data, addr[LSB]}, ctrl=1 write, 0 read; drives a memory port.
REQ-009 SHALL have ports dout_valid in 1, dout_ready out 1, dout_data in W_DATA: read responses from the memory port, in request order.
REQ-010 SHALL have ports rdat_valid out 1, rdat_ready in 1, rdat_data out W_DATA+1: {eot[MSB], data}: read data to downstream.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, WR, RD, DRAIN.
REQ-013 IDLE: cmd_ready=1; on cmd handshake latch addr, len, wr; clear issue count icnt and response count rcnt; go to WR if wr=1, else RD.
REQ-014 cmd_ready SHALL be 0 in all states except IDLE.
REQ-015 WR: req_valid=wdat_valid; wdat_ready=req_ready; req_data={1, wdat_data, addr+icnt}.
REQ-016 WR: on req handshake icnt increments; handshake with icnt==len returns to IDLE in the next cycle.
REQ-017 RD: req_valid=1; req_data={0, all-zero data, addr+icnt}; wdat_ready=0.
REQ-018 RD: on req handshake icnt increments; handshake with icnt==len moves to DRAIN.
REQ-019 In RD and DRAIN: rdat_valid=dout_valid, dout_ready=rdat_ready, rdat_data={eot, dout_data}, eot=(rcnt==len).
REQ-020 rcnt SHALL increment on each rdat handshake; handshake with eot=1 in DRAIN returns to IDLE next cycle.
REQ-021 If the eot response handshakes in RD in the same cycle as the last request (not possible with a 1-cycle-latency port, but defined), FSM SHALL return directly to IDLE.
REQ-022 In IDLE and WR: dout_ready=0, rdat_valid=0.
REQ-023 Address arithmetic addr+icnt SHALL wrap modulo 2^W_ADDR.
REQ-024 Counters icnt, rcnt SHALL be W_LEN bits; a burst of len=2^W_LEN-1 SHALL complete without overflow misbehaviour.
REQ-025 req_valid, once asserted in RD, SHALL hold with stable req_data until req_ready.
REQ-026 All outputs other than busy SHALL be combinational from state/counters/inputs; no added latency: first req_valid appears the cycle after cmd handshake.
REQ-027 Back-to-back commands: a new cmd SHALL be accepted in the first IDLE cycle after burst completion (1 idle cycle minimum between bursts).

Reset
REQ-028 rst=0 SHALL immediately force state=IDLE, icnt=0, rcnt=0, latched cmd fields=0, busy=0.
REQ-029 During reset: cmd_ready=1, req_valid=0, wdat_ready=0, dout_ready=0, rdat_valid=0.
REQ-030 Reset mid-burst SHALL abandon the burst; the attached memory port SHALL share the same reset so no stale response remains.

Verification
REQ-031 Write burst: cmd {wr=1,len=3,addr=0x10}, wdat 0xA,0xB,0xC,0xD -> req_data writes to 0x10..0x13, ctrl=1, busy falls after 4th handshake.
REQ-032 Read burst with 1-cycle memory: cmd {wr=0,len=3,addr=0x10} after REQ-031 -> rdat 0xA,0xB,0xC,0xD, eot only on 0xD, return to IDLE.
REQ-033 Backpressure: rdat_ready toggled randomly 50% during len=7 read -> no lost/duplicated data, order preserved, req_data stable while stalled.
REQ-034 Wrap: W_ADDR=4, read {len=3,addr=0xE} -> addresses 0xE,0xF,0x0,0x1.
REQ-035 Single word len=0 read and write -> one req each, read eot=1 on the only word.
REQ-036 Reset asserted after 2nd request of len=7 read -> outputs at reset values same cycle; next cmd accepted and executes correctly.
